// File: rtl/DataType.sv
// rtl/DataType.sv - shared SRAM request/result types and the VGA fetcher state enum
package DataType;
    localparam int SRAM_ADDRESS_WIDTH = 18;
    localparam int SRAM_DATA_WIDTH    = 16;

    typedef struct packed {
        logic [SRAM_ADDRESS_WIDTH-1:0] address;
        logic [SRAM_DATA_WIDTH-1:0]    dout;
        logic                          oe_n;
        logic                          we_n;
        logic                          den;
    } SramRequest_t;

    typedef struct packed {
        logic [SRAM_DATA_WIDTH-1:0] din;
        logic                       done;
    } SramResult_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FRAME_DONE
    } VgaFetchState_t;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - power-of-two synchronous FIFO with flush, no push-to-pop bypass
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (r_count != FULL_COUNT);
    assign w_do_pop  = i_pop && (r_count != '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/vga_scan_fetcher.sv
// rtl/vga_scan_fetcher.sv - sequential framebuffer reader feeding a prefetch FIFO for the VGA pipeline
// Optional underflow counter port enabled by VGA_FETCH_STATS_EN.
module vga_scan_fetcher
    import DataType::*;
#(
    parameter logic [SRAM_ADDRESS_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                            FRAME_WORDS = 153600,
    parameter int                            FIFO_DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frameStart,
    output SramRequest_t               vgaRequest,
    input  SramResult_t                vgaResult,
    input  logic                       pixelReq,
    output logic [SRAM_DATA_WIDTH-1:0] pixelData,
    output logic                       pixelValid,
    output logic                       underflow
`ifdef VGA_FETCH_STATS_EN
    ,
    output logic [15:0]                underflowCount
`endif
);
    localparam int RW = SRAM_ADDRESS_WIDTH + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [RW-1:0] FRAME_WORDS_L = RW'(FRAME_WORDS);
    localparam logic [CW-1:0] FULL_COUNT    = CW'(FIFO_DEPTH);

    VgaFetchState_t                r_state;
    VgaFetchState_t                w_state_next;
    logic [SRAM_ADDRESS_WIDTH-1:0] r_addr;
    logic [RW-1:0]                 r_remaining;
    logic [SRAM_DATA_WIDTH-1:0]    r_pixel_data;
    logic                          r_pixel_valid;
    logic                          r_underflow;
    logic [CW-1:0]                 w_count;
    logic [SRAM_DATA_WIDTH-1:0]    w_head;
    logic                          w_read;
    logic                          w_push;
    logic                          w_empty;

    assign w_read  = (r_state == FETCH) && (w_count < FULL_COUNT);
    assign w_push  = w_read && vgaResult.done && !frameStart;
    assign w_empty = (w_count == '0);

    sync_fifo #(
        .WIDTH (SRAM_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (frameStart),
        .i_push      (w_push),
        .i_push_data (vgaResult.din),
        .i_pop       (pixelReq),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    always_comb begin
        w_state_next       = r_state;
        vgaRequest         = '0;
        vgaRequest.address = r_addr;
        vgaRequest.oe_n    = !w_read;
        vgaRequest.we_n    = 1'b1;
        if (frameStart) begin
            w_state_next = FETCH;
        end else if (w_push && (r_remaining == RW'(1))) begin
            w_state_next = FRAME_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_addr        <= BASE_ADDR;
            r_remaining   <= FRAME_WORDS_L;
            r_pixel_data  <= '0;
            r_pixel_valid <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (frameStart) begin
                r_addr      <= BASE_ADDR;
                r_remaining <= FRAME_WORDS_L;
            end else if (w_push) begin
                r_addr      <= r_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
            // The pop reads the pre-flush FIFO, so frameStart does not gate it.
            r_pixel_valid <= pixelReq;
            if (pixelReq) begin
                r_pixel_data <= w_empty ? '0 : w_head;
            end
            if (frameStart) begin
                r_underflow <= 1'b0;
            end else if (pixelReq && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign pixelData  = r_pixel_data;
    assign pixelValid = r_pixel_valid;
    assign underflow  = r_underflow;

`ifdef VGA_FETCH_STATS_EN
    logic [15:0] r_underflow_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_underflow_count <= '0;
        end else if (pixelReq && w_empty && (r_underflow_count != 16'hFFFF)) begin
            r_underflow_count <= r_underflow_count + 1'b1;
        end
    end

    assign underflowCount = r_underflow_count;
`endif
endmodule

// File: tb/tb_vga_scan_fetcher.sv
// tb/tb_vga_scan_fetcher.sv - randomized self-checking bench for vga_scan_fetcher against a queue model
module tb_vga_scan_fetcher;
    import DataType::*;

    localparam logic [17:0] BASE  = 18'h3FFFE;
    localparam logic [17:0] MID   = BASE + 18'd5;
    localparam int          FW    = 20;
    localparam int          DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         frameStart;
    logic         pixelReq;
    SramRequest_t vgaRequest;
    SramResult_t  vgaResult;
    logic [15:0]  pixelData;
    logic         pixelValid;
    logic         underflow;
`ifdef VGA_FETCH_STATS_EN
    logic [15:0]  underflowCount;
`endif

    always #5 clk = ~clk;

    vga_scan_fetcher #(
        .BASE_ADDR   (BASE),
        .FRAME_WORDS (FW),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frameStart (frameStart),
        .vgaRequest (vgaRequest),
        .vgaResult  (vgaResult),
        .pixelReq   (pixelReq),
        .pixelData  (pixelData),
        .pixelValid (pixelValid),
        .underflow  (underflow)
`ifdef VGA_FETCH_STATS_EN
        ,
        .underflowCount (underflowCount)
`endif
    );

    int          passed = 0;
    int          total  = 0;
    bit          m_active;
    int          m_fetched;
    logic [17:0] m_addr;
    logic [15:0] m_q[$];
    bit          m_uf;
    logic [15:0] exp_pd;
    bit          exp_pv;
    int          m_stats;
    bit          phase;

    function automatic logic [15:0] sram_word(input logic [17:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    function automatic bit read_now();
        return m_active && (m_q.size() < DEPTH);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_active  = 1'b0;
        m_fetched = 0;
        m_addr    = BASE;
        m_q.delete();
        m_uf      = 1'b0;
        exp_pd    = '0;
        exp_pv    = 1'b0;
        m_stats   = 0;
    endtask

    task automatic check_outputs();
        chk("oe_n",       32'(vgaRequest.oe_n),    32'(!read_now()));
        chk("we_n",       32'(vgaRequest.we_n),    32'd1);
        chk("den",        32'(vgaRequest.den),     32'd0);
        chk("dout",       32'(vgaRequest.dout),    32'd0);
        chk("address",    32'(vgaRequest.address), 32'(m_addr));
        chk("pixelValid", 32'(pixelValid),         32'(exp_pv));
        chk("pixelData",  32'(pixelData),          32'(exp_pd));
        chk("underflow",  32'(underflow),          32'(m_uf));
`ifdef VGA_FETCH_STATS_EN
        chk("underflowCount", 32'(underflowCount), 32'(m_stats));
`endif
    endtask

    task automatic step(input bit fs, input bit preq);
        bit rd;
        bit uf_ev;
        check_outputs();
        frameStart     = fs;
        pixelReq       = preq;
        vgaResult.done = phase;
        vgaResult.din  = phase ? sram_word(vgaRequest.address) : 16'hDEAD;
        rd    = read_now();
        uf_ev = 1'b0;
        exp_pv = preq;
        if (preq) begin
            if (m_q.size() > 0) begin
                exp_pd = m_q.pop_front();
            end else begin
                exp_pd = '0;
                uf_ev  = 1'b1;
            end
        end
        if (rd && phase && !fs) begin
            m_q.push_back(sram_word(m_addr));
            m_addr = m_addr + 18'd1;
            m_fetched++;
            if (m_fetched == FW) m_active = 1'b0;
        end
        if (fs) begin
            m_q.delete();
            m_addr    = BASE;
            m_fetched = 0;
            m_active  = 1'b1;
            m_uf      = 1'b0;
        end else if (uf_ev) begin
            m_uf = 1'b1;
        end
        if (uf_ev && m_stats < 65535) m_stats++;
        @(posedge clk);
        #1;
        phase = ~phase;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        frameStart     = 1'b0;
        pixelReq       = 1'b0;
        vgaResult      = '0;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        phase = ~phase;
        model_reset();
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        frameStart = 1'b0;
        pixelReq   = 1'b0;
        vgaResult  = '0;
        phase      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset values, then fill the FIFO with no pops until reads stall
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (30) step(1'b0, 1'b0);
        chk("fifo_full_size", 32'(m_q.size()), 32'(DEPTH));

        // slow drain through the end of the frame and into underflow
        for (int i = 0; i < 120; i++) step(1'b0, (i % 4) == 0);

        // pop every cycle from the frame start
        step(1'b1, 1'b0);
        repeat (60) step(1'b0, 1'b1);

        // restart during a done cycle in mid-frame
        step(1'b1, 1'b0);
        n = 0;
        while (!(m_active && m_addr == MID && phase && read_now()) && n < 200) begin
            step(1'b0, 1'b0);
            n++;
        end
        if (n >= 200) begin
            total++;
            $error("FAIL reach_mid observed=timeout expected=addr %0h", MID);
        end
        step(1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0);
        repeat (20) step(1'b0, 1'b1);

        // random traffic with occasional restarts
        repeat (400) step($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0);

        // reset mid-frame, then underflows across a restart
        step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        do_reset();
        repeat (2) step(1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
